// File: rtl/parser_pkg.sv
// parser_pkg: widths, valid-tag encodings and metadata layout shared by the parser front end.
package parser_pkg;
  localparam int HEAD_WIDTH = 512;
  localparam int META_WIDTH = 32;
  localparam int TAG_START_BIT = 4;
  localparam int META_SHIFT_WIDTH = 4;
  localparam int TAG_WIDTH = 4 + TAG_START_BIT;
  localparam logic [TAG_WIDTH-1:0] HEAD_TAG_VALID = {4'b1101, {TAG_START_BIT{1'b1}}};
  localparam logic [TAG_WIDTH-1:0] META_TAG_VALID = {4'b1111, {META_SHIFT_WIDTH{1'b0}}};
  localparam int META_LEN_MSB = META_WIDTH - 1;
  localparam int META_PORT_MSB = META_WIDTH - 17;
  localparam int META_TRUNC_BIT = META_WIDTH - 25;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} hb_state_t;
  // Fields sit MSB-first; any bits below the truncation flag stay zero.
  function automatic logic [META_WIDTH-1:0] meta_pack(input logic [15:0] len, input logic [7:0] port,
                                                      input logic trunc);
    meta_pack = '0;
    meta_pack[META_LEN_MSB -: 16] = len;
    meta_pack[META_PORT_MSB -: 8] = port;
    meta_pack[META_TRUNC_BIT] = trunc;
  endfunction
endpackage

// File: rtl/pkt_head_builder_beat_byte_mask.sv
// beat_byte_mask: zeroes the bytes past the valid count of an eop beat (byte 0 in the MSBs).
module beat_byte_mask #(
  parameter int BEAT_WIDTH = 128
) (
  input  logic [BEAT_WIDTH-1:0]              i_data,
  input  logic [$clog2(BEAT_WIDTH/8)-1:0]    i_bytes,
  input  logic                               i_eop,
  output logic [BEAT_WIDTH-1:0]              o_data
);
  localparam int NB = BEAT_WIDTH / 8;
  localparam int BW = $clog2(NB);
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign o_data[BEAT_WIDTH-1-8*b -: 8] =
      (i_eop && i_bytes != '0 && BW'(b) >= i_bytes) ? 8'h00 : i_data[BEAT_WIDTH-1-8*b -: 8];
  end
endmodule

// File: rtl/pkt_head_builder.sv
// pkt_head_builder: assembles the first HEAD_WIDTH bits of each packet and emits tagged
// head/meta words for Parser_Top one cycle after eop.
module pkt_head_builder
  import parser_pkg::*;
#(
  parameter int         BEAT_WIDTH = 128,
  parameter logic [7:0] PORT_ID    = 8'd0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_pkt_valid,
  input  logic                               i_pkt_sop,
  input  logic                               i_pkt_eop,
  input  logic [$clog2(BEAT_WIDTH/8)-1:0]    i_pkt_bytes,
  input  logic [BEAT_WIDTH-1:0]              i_pkt_data,
  output logic                               o_pkt_ready,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]    o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]    o_meta,
  output logic [31:0]                        o_pkt_cnt,
  output logic [15:0]                        o_err_cnt
);
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int HEAD_BEATS = HEAD_WIDTH / BEAT_WIDTH;
  localparam int IDX_W = $clog2(HEAD_BEATS) + 1;
  hb_state_t state_q, state_d;
  logic [HEAD_WIDTH-1:0] asm_q, asm_d, asm_base;
  logic [15:0] len_q, len_d, len_base;
  logic [16:0] len_sum;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d, slot;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q, head_d;
  logic [META_WIDTH+TAG_WIDTH-1:0] meta_q, meta_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic ready_q;
  logic [BEAT_WIDTH-1:0] beat_masked;
  logic start, live, store, emit, err;
  beat_byte_mask #(.BEAT_WIDTH(BEAT_WIDTH)) u_mask (
    .i_data (i_pkt_data),
    .i_bytes(i_pkt_bytes),
    .i_eop  (i_pkt_eop),
    .o_data (beat_masked)
  );
  // A sop always restarts assembly, even mid-packet; that abort is counted as an error.
  always_comb begin
    start = i_pkt_valid & i_pkt_sop;
    live = start | (i_pkt_valid & (state_q != IDLE));
    store = start | (i_pkt_valid & (state_q == COLLECT));
    emit = live & i_pkt_eop;
    err = i_pkt_valid & (i_pkt_sop ^ (state_q == IDLE));
    slot = start ? '0 : beat_idx_q;
    asm_base = start ? '0 : asm_q;
    asm_d = store ? asm_base | (HEAD_WIDTH'(beat_masked) << ((HEAD_BEATS - 1 - int'(slot)) * BEAT_WIDTH))
                  : asm_base;
    len_base = start ? '0 : len_q;
    len_sum = {1'b0, len_base} + ((i_pkt_eop && i_pkt_bytes != '0) ? 17'(i_pkt_bytes) : 17'(BEAT_BYTES));
    len_d = !live ? len_q : len_sum[16] ? 16'hFFFF : len_sum[15:0];
    state_d = emit ? IDLE
            : start ? (HEAD_BEATS == 1 ? DRAIN : COLLECT)
            : (store && beat_idx_q == IDX_W'(HEAD_BEATS - 1)) ? DRAIN
            : state_q;
    beat_idx_d = emit ? '0 : store ? slot + 1'b1 : beat_idx_q;
    head_d = emit ? {HEAD_TAG_VALID, asm_d} : '0;
    meta_d = emit ? {META_TAG_VALID, meta_pack(len_d, PORT_ID, len_d > 16'(HEAD_WIDTH / 8))} : '0;
    pkt_cnt_d = pkt_cnt_q + 32'(emit);
    err_cnt_d = (err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      asm_q <= '0;
      len_q <= '0;
      beat_idx_q <= '0;
      head_q <= '0;
      meta_q <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q <= asm_d;
      len_q <= len_d;
      beat_idx_q <= beat_idx_d;
      head_q <= head_d;
      meta_q <= meta_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      ready_q <= 1'b1;
    end
  end
  assign o_pkt_ready = ready_q;
  assign o_head = head_q;
  assign o_meta = meta_q;
  assign o_pkt_cnt = pkt_cnt_q;
  assign o_err_cnt = err_cnt_q;
endmodule
